// File: rtl/move_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : move_sequencer_if
//  Description : Host-side and stepper-side signal bundle of the move
//                sequencer. The master modport is the host/stepper side, the
//                slave modport is the sequencer itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface move_sequencer_if;
   logic [3:0] load_move;
   logic       load_valid;
   logic       load_ready;
   logic       go;
   logic       abort;
   logic [3:0] next_move;
   logic       move_start;
   logic       move_done;
   logic       busy;
   logic       seq_done;
   logic [7:0] move_count;
   logic       error;

   modport master (
      output load_move, load_valid, go, abort, move_done,
      input  load_ready, next_move, move_start, busy, seq_done, move_count, error
   );

   modport slave (
      input  load_move, load_valid, go, abort, move_done,
      output load_ready, next_move, move_start, busy, seq_done, move_count, error
   );
endinterface
`default_nettype wire

// File: rtl/move_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : move_sequencer
//  Description : Queues cube-face move codes in a FIFO and issues them one at
//                a time to the stepper block, waiting for each move to start
//                (move_done low) and finish (move_done high).
//                Optional build macro MOVE_SEQ_CANCEL_EN: adjacent queued
//                moves of the same face in opposite directions cancel out and
//                are popped together without being issued.
//  Revision    : 1.0 - initial release
// ============================================================================
module move_sequencer #(
   parameter int DEPTH        = 32,
   parameter int BUSY_TIMEOUT = 1000
) (
   input  wire logic       clock,
   input  wire logic       reset,
   move_sequencer_if.slave bus
);

   localparam int c_addr_w = $clog2(DEPTH);
   localparam int c_tmo_w  = $clog2(BUSY_TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_ISSUE     = 3'd1,
      S_WAIT_BUSY = 3'd2,
      S_WAIT_DONE = 3'd3,
      S_DRAIN     = 3'd4
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic [3:0]          r_mem [DEPTH];
   logic [c_addr_w-1:0] r_rd_ptr;
   logic [c_addr_w-1:0] r_wr_ptr;
   logic [c_addr_w:0]   r_count;

   logic [3:0]          r_next_move;
   logic                r_move_start;
   logic                r_seq_done;
   logic [7:0]          r_move_count;
   logic                r_error;
   logic [c_tmo_w-1:0]  r_tmo;
   logic                r_drain_fall;

   logic [3:0]          w_head;
   logic                w_empty;
   logic                w_head_valid;
   logic                w_cancel;
   logic                w_tmo_hit;
   logic                w_wr;
   logic                w_flush;
   logic [1:0]          w_pop_n;
   logic                w_issue;
   logic                w_set_err;
   logic                w_start_run;
   logic                w_tmo_en;
   logic                w_seq_done;
   logic                w_drain_fall_set;
   logic                w_drain_fall_clr;

   assign w_head       = r_mem[r_rd_ptr];
   assign w_empty      = (r_count == '0);
   assign w_head_valid = (w_head >= 4'd2) && (w_head <= 4'd13);
   assign w_tmo_hit    = (r_tmo == c_tmo_w'(BUSY_TIMEOUT - 1));

`ifdef MOVE_SEQ_CANCEL_EN
   logic [c_addr_w-1:0] w_rd_ptr_p1;
   logic [3:0]          w_second;
   logic                w_has_two;

   assign w_rd_ptr_p1 = r_rd_ptr + c_addr_w'(1);
   assign w_second    = r_mem[w_rd_ptr_p1];
   assign w_has_two   = (r_count >= (c_addr_w + 1)'(2));
   // A valid head followed by its inverse on the same face is a no-op pair.
   assign w_cancel    = w_has_two && w_head_valid &&
                        (w_head[3:1] == w_second[3:1]) &&
                        (w_head[0] != w_second[0]);
`else
   assign w_cancel    = 1'b0;
`endif

   // A write is accepted when there is room, or when full but an entry is
   // popped in the same cycle (occupancy then stays at DEPTH). Flush wins.
   assign w_wr = bus.load_valid && (!r_count[c_addr_w] || (w_pop_n != 2'd0)) && !w_flush;

   assign bus.load_ready = !r_count[c_addr_w];
   assign bus.next_move  = r_next_move;
   assign bus.move_start = r_move_start;
   assign bus.busy       = (r_state != S_IDLE);
   assign bus.seq_done   = r_seq_done;
   assign bus.move_count = r_move_count;
   assign bus.error      = r_error;

   // Next-state and control decode of the sequencing FSM.
   always_comb begin
      w_state_nxt      = r_state;
      w_pop_n          = 2'd0;
      w_issue          = 1'b0;
      w_flush          = bus.abort;
      w_set_err        = 1'b0;
      w_start_run      = 1'b0;
      w_tmo_en         = 1'b0;
      w_seq_done       = 1'b0;
      w_drain_fall_set = 1'b0;
      w_drain_fall_clr = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (!bus.abort && bus.go && !w_empty) begin
               w_state_nxt = S_ISSUE;
               w_start_run = 1'b1;
            end
         end

         S_ISSUE: begin
            if (w_empty) begin
               // Only reachable after a cancelled pair emptied the queue.
               w_state_nxt = S_WAIT_DONE;
            end else if (w_cancel) begin
               w_pop_n     = 2'd2;
               w_state_nxt = S_ISSUE;
            end else begin
               w_pop_n = 2'd1;
               if (w_head_valid) begin
                  w_issue     = 1'b1;
                  w_state_nxt = S_WAIT_BUSY;
               end else begin
                  w_set_err   = 1'b1;
                  w_state_nxt = S_WAIT_DONE;
               end
            end
            if (bus.abort) begin
               w_state_nxt      = S_DRAIN;
               w_drain_fall_set = w_issue;
            end
         end

         S_WAIT_BUSY: begin
            w_tmo_en = 1'b1;
            if (!bus.move_done) begin
               w_state_nxt = S_WAIT_DONE;
            end else if (w_tmo_hit) begin
               w_set_err   = 1'b1;
               w_state_nxt = S_WAIT_DONE;
            end
            if (bus.abort) begin
               w_state_nxt      = S_DRAIN;
               w_drain_fall_set = bus.move_done && !w_tmo_hit;
            end
         end

         S_WAIT_DONE: begin
            if (bus.move_done) begin
               if (w_empty) begin
                  w_state_nxt = S_IDLE;
                  w_seq_done  = !bus.abort;
               end else begin
                  w_state_nxt = S_ISSUE;
               end
            end
            if (bus.abort) begin
               w_state_nxt = S_DRAIN;
            end
         end

         S_DRAIN: begin
            // A move issued just before the abort must first be seen to start.
            if (r_drain_fall) begin
               w_tmo_en = 1'b1;
               if (!bus.move_done || w_tmo_hit) begin
                  w_drain_fall_clr = 1'b1;
                  w_set_err        = bus.move_done;
               end
            end else if (bus.move_done) begin
               w_state_nxt = S_IDLE;
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FIFO storage; contents need no reset since occupancy gates every read.
   always_ff @(posedge clock) begin
      if (w_wr) begin
         r_mem[r_wr_ptr] <= bus.load_move;
      end
   end

   // FIFO pointers and occupancy; flush discards everything including a
   // same-cycle write.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (w_flush) begin
         r_rd_ptr <= r_wr_ptr;
         r_count  <= '0;
      end else begin
         r_rd_ptr <= r_rd_ptr + c_addr_w'(w_pop_n);
         r_count  <= r_count + (c_addr_w + 1)'(w_wr) - (c_addr_w + 1)'(w_pop_n);
         if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + c_addr_w'(1);
         end
      end
   end

   // Output registers: move_start and next_move change together so the
   // stepper sees the new code in the same cycle as the start pulse.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_next_move  <= 4'd0;
         r_move_start <= 1'b0;
         r_seq_done   <= 1'b0;
         r_move_count <= 8'd0;
         r_error      <= 1'b0;
      end else begin
         r_move_start <= w_issue;
         r_seq_done   <= w_seq_done;
         if (w_issue) begin
            r_next_move <= w_head;
         end
         if (w_start_run) begin
            r_move_count <= 8'd0;
         end else if (w_issue && (r_move_count != 8'd255)) begin
            r_move_count <= r_move_count + 8'd1;
         end
         if (w_start_run) begin
            r_error <= 1'b0;
         end else if (w_set_err) begin
            r_error <= 1'b1;
         end
      end
   end

   // Busy timeout counter and the drain-phase wait-for-start flag.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_tmo        <= '0;
         r_drain_fall <= 1'b0;
      end else begin
         if (w_tmo_en && bus.move_done && !w_tmo_hit) begin
            r_tmo <= r_tmo + c_tmo_w'(1);
         end else begin
            r_tmo <= '0;
         end
         if (w_drain_fall_set) begin
            r_drain_fall <= 1'b1;
         end else if (w_drain_fall_clr) begin
            r_drain_fall <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire
